// File: rtl/secret_poly_unpack_buffer_pkg.sv
// secret_poly_unpack_buffer_pkg: shared constants and FSM state type for the secret-poly unpack buffer
package secret_poly_unpack_buffer_pkg;
  localparam int SABER_N = 256;
  localparam int SABER_Q_W = 13;
  localparam int SABER_S_COEF_W = 4;
  typedef enum logic [1:0] {IDLE, LOAD, SERVE, DONE} state_t;
endpackage

// File: rtl/secret_poly_unpack_buffer_coef_lane_select.sv
// coef_lane_select: picks COEF_LANES packed coefficients from a word and sign-extends each to OUT_W
module coef_lane_select #(
  parameter int WORD_W     = 64,
  parameter int COEF_W     = 4,
  parameter int OUT_W      = 13,
  parameter int COEF_LANES = 4,
  parameter int LO_W       = 2
) (
  input  logic [WORD_W-1:0]           i_word,
  input  logic [LO_W-1:0]             i_lane_off,
  output logic [COEF_LANES*OUT_W-1:0] o_coeffs
);
  logic [COEF_W-1:0] w_c;
  // Slice lane group i_lane_off out of the word, little-endian, and sign-replicate each nibble
  always_comb begin
    o_coeffs = '0;
    w_c = '0;
    for (int k = 0; k < COEF_LANES; k++) begin
      w_c = i_word[(int'(i_lane_off) * COEF_LANES + k) * COEF_W +: COEF_W];
      o_coeffs[k*OUT_W +: OUT_W] = {{(OUT_W-COEF_W){w_c[COEF_W-1]}}, w_c};
    end
  end
endmodule

// File: rtl/secret_poly_unpack_buffer.sv
// secret_poly_unpack_buffer: captures packed secret-poly words from BRAM and serves sign-extended lanes
module secret_poly_unpack_buffer
  import secret_poly_unpack_buffer_pkg::*;
#(
  parameter int WORD_W     = 64,
  parameter int COEF_W     = SABER_S_COEF_W,
  parameter int OUT_W      = SABER_Q_W,
  parameter int NUM_WORDS  = SABER_N * COEF_W / WORD_W,
  parameter int COEF_LANES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [WORD_W-1:0]           word_in,
  input  logic                        word_valid,
  output logic [COEF_LANES*OUT_W-1:0] out_coeffs,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow_err
);
  localparam int CPW   = WORD_W / COEF_W;
  localparam int BPW   = CPW / COEF_LANES;
  localparam int BEATS = NUM_WORDS * BPW;
  localparam int WP_W  = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  localparam int BT_W  = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int LO_W  = BPW > 1 ? $clog2(BPW) : 1;

  state_t            r_state, w_next;
  logic [WP_W-1:0]   r_wr_ptr, w_wr_idx, w_word_idx;
  logic [BT_W-1:0]   r_beat;
  logic [LO_W-1:0]   w_lane_off;
  logic              r_ovf;
  logic [WORD_W-1:0] r_buf [NUM_WORDS];
  logic              w_start, w_wr_en, w_last_wr, w_accept, w_last_beat;

  assign w_start      = r_state == IDLE && start;
  assign w_wr_en      = word_valid && (w_start || r_state == LOAD);
  assign w_wr_idx     = w_start ? '0 : r_wr_ptr;
  assign w_last_wr    = w_wr_en && w_wr_idx == WP_W'(NUM_WORDS - 1);
  assign out_valid    = r_state == SERVE;
  assign w_accept     = out_valid && out_ready;
  assign w_last_beat  = r_beat == BT_W'(BEATS - 1);
  assign busy         = r_state != IDLE;
  assign done         = r_state == DONE;
  assign overflow_err = r_ovf;
  assign w_word_idx   = WP_W'(r_beat / BT_W'(BPW));
  assign w_lane_off   = LO_W'(r_beat % BT_W'(BPW));

  // Next state: a word landing in the last slot (even together with start) goes straight to SERVE
  always_comb begin
    w_next = r_state;
    w_next = w_last_wr ? SERVE :
             w_start ? LOAD :
             (w_accept && w_last_beat) ? DONE :
             r_state == DONE ? IDLE : r_state;
  end

  // State, write pointer, beat counter and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_beat   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_wr_ptr <= w_wr_en ? w_wr_idx + 1'b1 : w_start ? '0 : r_wr_ptr;
      r_beat   <= w_start ? '0 : w_accept ? (w_last_beat ? '0 : r_beat + 1'b1) : r_beat;
      r_ovf    <= w_start ? 1'b0 : r_ovf | (word_valid & ~w_wr_en);
    end
  end

  // Word buffer; deliberately unreset so it can map to distributed RAM
  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[w_wr_idx] <= word_in;
  end

  coef_lane_select #(
    .WORD_W(WORD_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .COEF_LANES(COEF_LANES), .LO_W(LO_W)
  ) u_sel (
    .i_word(r_buf[w_word_idx]),
    .i_lane_off(w_lane_off),
    .o_coeffs(out_coeffs)
  );
endmodule

// File: tb/tb_secret_poly_unpack_buffer.sv
// tb_secret_poly_unpack_buffer: directed, table-driven self-checking bench for the unpack buffer
module tb_secret_poly_unpack_buffer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, word_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] word_in = '0;
  logic [51:0] out_coeffs;
  logic        out_valid, busy, done, overflow_err;

  always #5 clk = ~clk;

  secret_poly_unpack_buffer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_in(word_in), .word_valid(word_valid),
    .out_coeffs(out_coeffs), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow_err(overflow_err)
  );

  typedef struct {int beat; logic [51:0] exp;} vec_t;
  vec_t        tbl [6];
  int          n_tests = 0, n_fail = 0;
  logic [63:0] w [16];
  logic [51:0] got [64];
  logic [51:0] ref1 [64];
  int          acc, cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [51:0] model(input int b);
    logic [51:0] r;
    logic [3:0]  n;
    int          j;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      j = b * 4 + k;
      n = w[j / 16][4 * (j % 16) +: 4];
      r[k*13 +: 13] = {{9{n[3]}}, n};
    end
    return r;
  endfunction

  task automatic load(input bit merged, input int gap_after, input int gap_len);
    start = 1'b1;
    if (!merged) begin
      tick;
      start = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      word_valid = 1'b1;
      word_in = w[i];
      tick;
      start = 1'b0;
      word_valid = 1'b0;
      check("load_out_valid", out_valid, i == 15);
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          tick;
          check("gap_out_valid", out_valid, 0);
          check("gap_busy", busy, 1);
        end
      end
    end
  endtask

  task automatic serve(input bit stall, input int inj, input int abort, output int a, output int c);
    logic [51:0] held;
    bit          stalled, injd;
    held = '0;
    stalled = 0;
    injd = 0;
    a = 0;
    c = 0;
    while (1) begin
      if (c >= 400) begin
        check("serve_timeout", c, 0);
        break;
      end
      if (abort >= 0 && a == abort) begin
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        break;
      end
      out_ready = stall ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      word_valid = inj >= 0 && a == inj && !injd;
      if (word_valid) begin
        injd = 1;
        word_in = '1;
      end
      if (stalled) check("stall_hold", out_coeffs, held);
      stalled = out_valid && !out_ready;
      held = out_coeffs;
      if (out_valid && out_ready) begin
        if (a < 64) got[a] = out_coeffs;
        a++;
      end
      tick;
      c++;
      word_valid = 1'b0;
      if (done) break;
    end
    out_ready = 1'b0;
    word_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{0,  {4{13'h0000}}};
    tbl[1] = '{4,  {4{13'h0001}}};
    tbl[2] = '{28, {4{13'h0007}}};
    tbl[3] = '{32, {4{13'h1FF8}}};
    tbl[4] = '{44, {4{13'h1FFB}}};
    tbl[5] = '{63, {4{13'h1FFF}}};

    repeat (2) tick;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow_err, 0);
    rst_n = 1'b1;
    tick;

    word_valid = 1'b1;
    tick;
    word_valid = 1'b0;
    check("idle_ovf", overflow_err, 1);
    check("idle_busy", busy, 0);

    for (int i = 0; i < 16; i++) w[i] = {16{4'(i)}};
    load(0, -1, 0);
    check("start_clears_ovf", overflow_err, 0);
    serve(0, -1, -1, acc, cyc);
    check("t1_accepts", acc, 64);
    check("t1_done_cycle", 17 + cyc, 81);
    check("t1_done", done, 1);
    tick;
    check("t1_done_pulse", done, 0);
    check("t1_idle_busy", busy, 0);
    for (int i = 0; i < 6; i++) check("t1_vec", got[tbl[i].beat], tbl[i].exp);
    for (int b = 0; b < 64; b++) begin
      check("t1_model", got[b], model(b));
      ref1[b] = got[b];
    end

    load(0, 7, 3);
    serve(0, -1, -1, acc, cyc);
    check("t2_accepts", acc, 64);
    for (int b = 0; b < 64; b++) check("t2_same", got[b], ref1[b]);
    tick;

    for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
    w[0][15:0] = 16'h7C84;
    load(0, -1, 0);
    serve(1, -1, -1, acc, cyc);
    check("t3_accepts", acc, 64);
    check("t4_lanes", got[0], {13'h0007, 13'h1FFC, 13'h1FF8, 13'h0004});
    for (int b = 0; b < 64; b++) check("t3_model", got[b], model(b));
    tick;

    for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
    load(0, -1, 0);
    serve(0, 10, -1, acc, cyc);
    check("t5_accepts", acc, 64);
    check("t5_ovf_set", overflow_err, 1);
    for (int b = 0; b < 64; b++) check("t5_model", got[b], model(b));
    tick;
    check("t5_ovf_sticky", overflow_err, 1);

    for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom};
    load(1, -1, 0);
    check("t5_ovf_cleared", overflow_err, 0);
    serve(0, -1, 20, acc, cyc);
    check("t6_abort_beat", acc, 20);
    tick;
    rst_n = 1'b1;
    tick;
    check("t6_idle_busy", busy, 0);
    for (int i = 0; i < 16; i++) w[i] = {$urandom, $urandom} ^ 64'hA5A5_5A5A_0F0F_F0F0;
    load(0, -1, 0);
    serve(0, -1, -1, acc, cyc);
    check("t6_accepts", acc, 64);
    for (int b = 0; b < 64; b++) check("t6_model", got[b], model(b));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
